// File: rtl/bball_pkg.sv
// Shared constants for the basketball scoreboard blocks:
// FSM state codes, shot-clock length and game defaults.
package bball_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_PAUSE     = 3'd2;
    localparam logic [2:0] ST_SHOT_VIOL = 3'd3;
    localparam logic [2:0] ST_QTR_END   = 3'd4;
    localparam logic [2:0] ST_GAME_OVER = 3'd5;

    localparam int SHOT_SEC       = 24;
    localparam int QTR_SEC_DEF    = 600;
    localparam int QUARTERS_DEF   = 4;
    localparam int BUZZ_TICKS_DEF = 3;
    localparam int SEC_W_DEF      = 10;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        RUN       = ST_RUN,
        PAUSE     = ST_PAUSE,
        SHOT_VIOL = ST_SHOT_VIOL,
        QTR_END   = ST_QTR_END,
        GAME_OVER = ST_GAME_OVER
    } state_e;

    function automatic logic is_alarm(input state_e s);
        return s inside {SHOT_VIOL, QTR_END, GAME_OVER};
    endfunction

endpackage

// File: rtl/bball_buzz_timer.sv
// Buzzer duration timer: load restarts the count, each tick
// counts down, busy stays high until the count reaches zero.
module bball_buzz_timer #(
    parameter int TICKS = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic load_i,
    output logic busy_o
);

    localparam int CW = $clog2(TICKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(TICKS);
        end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/bball_timer_ctrl.sv
// Game-level timing controller: run/pause FSM, quarter clock,
// shot-clock reload stretcher and buzzer arbitration.
module bball_timer_ctrl
    import bball_pkg::*;
#(
    parameter int QTR_SEC    = QTR_SEC_DEF,
    parameter int QUARTERS   = QUARTERS_DEF,
    parameter int BUZZ_TICKS = BUZZ_TICKS_DEF,
    parameter int SEC_W      = SEC_W_DEF
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             tick_1Hz,
    input  logic             btn_start,
    input  logic             btn_shot,
    input  logic             shot_zero,
    output logic             shot_en,
    output logic             shot_reload,
    output logic [SEC_W-1:0] game_sec,
    output logic [2:0]       quarter,
    output logic             buzzer,
    output logic [2:0]       state
);

    state_e           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [2:0]       qtr_q, qtr_d;
    logic             reload_q, reload_d;
    logic             set_rl;
    logic             buzz_load;

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        qtr_d   = qtr_q;
        set_rl  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_start) state_d = RUN;
            end
            RUN: begin
                set_rl = btn_shot;
                if (tick_1Hz && sec_q == SEC_W'(1)) begin
                    sec_d   = '0;
                    state_d = (qtr_q == 3'(QUARTERS)) ? GAME_OVER : QTR_END;
                end else begin
                    if (tick_1Hz && sec_q != '0) sec_d = sec_q - 1'b1;
                    if (shot_zero && !reload_q) state_d = SHOT_VIOL;
                    else if (btn_start)         state_d = PAUSE;
                end
            end
            PAUSE: begin
                set_rl = btn_shot;
                if (btn_start) state_d = RUN;
            end
            SHOT_VIOL: begin
                if (btn_shot) begin
                    set_rl  = 1'b1;
                    state_d = PAUSE;
                end
            end
            QTR_END: begin
                if (btn_start) begin
                    qtr_d   = qtr_q + 3'd1;
                    sec_d   = SEC_W'(QTR_SEC);
                    set_rl  = 1'b1;
                    state_d = IDLE;
                end
            end
            GAME_OVER: ;
            default: state_d = IDLE;
        endcase
    end

    // Reload is stretched until the 1 Hz counter has seen one tick with it.
    always_comb begin
        reload_d = set_rl;
        if (state_d == IDLE) reload_d = 1'b1;
        else if (reload_q)   reload_d = !tick_1Hz;
    end

    assign buzz_load = is_alarm(state_d) && (state_d != state_q);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            sec_q    <= SEC_W'(QTR_SEC);
            qtr_q    <= 3'd1;
            reload_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            qtr_q    <= qtr_d;
            reload_q <= reload_d;
        end
    end

    bball_buzz_timer #(
        .TICKS (BUZZ_TICKS)
    ) u_buzz (
        .clk_i  (clk),
        .rst_ni (Reset_n),
        .tick_i (tick_1Hz),
        .load_i (buzz_load),
        .busy_o (buzzer)
    );

    assign shot_en     = (state_q == RUN);
    assign shot_reload = reload_q;
    assign game_sec    = sec_q;
    assign quarter     = qtr_q;
    assign state       = state_q;

endmodule

// File: doc/bball_timer_ctrl.md
Name: bball_timer_ctrl

Overview:
Game-level timing controller for the basketball scoreboard.
- Sequences the 24 s shot-clock counter by driving its enable and reload lines and sampling its zero flag.
- Owns the quarter game clock (seconds) and the quarter number.
- Arbitrates the shared buzzer between shot-violation and end-of-quarter events.
- Sits between the button front-end (debounced one-cycle pulses) and the shot-clock counter and display logic.

Parameters:
QTR_SEC, 600, quarter length in seconds (reload value of game_sec)
QUARTERS, 4, number of quarters per game
BUZZ_TICKS, 3, buzzer duration in 1 Hz ticks
SEC_W, 10, width of game_sec; must satisfy 2^SEC_W > QTR_SEC

Ports:
clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
tick_1Hz  in  1  one-clk-wide pulse once per second, synchronous to clk
btn_start  in  1  one-cycle pulse: start/pause toggle, also quarter advance
btn_shot  in  1  one-cycle pulse: shot-clock reset (possession change)
shot_zero  in  1  shot counter terminal flag (counter value == 0)
shot_en  out  1  enable to shot-clock counter
shot_reload  out  1  synchronous reload request to shot-clock counter (to 24)
game_sec  out  SEC_W  remaining quarter seconds
quarter  out  3  current quarter, 1..QUARTERS
buzzer  out  1  buzzer drive
state  out  3  FSM state code, for display

Behaviour:
- Reset (async, Reset_n=0) values:
  - state=IDLE, game_sec=QTR_SEC, quarter=1.
  - shot_en=0, shot_reload=1, buzzer=0, buzz count=0.
- State encoding: IDLE=0, RUN=1, PAUSE=2, SHOT_VIOL=3, QTR_END=4, GAME_OVER=5. Codes 6 and 7 recover to IDLE on the next clk.
- shot_en = 1 only in RUN (combinational from state).
- shot_reload:
  - Held 1 throughout IDLE.
  - Otherwise set by btn_shot, or by a quarter advance.
  - Once set, stays 1 through the next tick_1Hz cycle inclusive, then clears on the following clk. This guarantees the 1 Hz-sampled counter observes it.
  - A second btn_shot while it is pending has no additional effect.
- Transitions (evaluated each clk, priority top-down):
  - IDLE:
    - btn_start -> RUN.
    - btn_shot is ignored, because reload is already held.
  - RUN:
    1. On a tick with game_sec==1: game_sec becomes 0 and the next state is QTR_END, or GAME_OVER if quarter==QUARTERS. This has priority over a simultaneous shot_zero.
    2. Else if shot_zero==1 and shot_reload==0: next state is SHOT_VIOL.
    3. Else btn_start -> PAUSE.
    4. On any other tick: game_sec decrements by 1.
  - PAUSE:
    - btn_start -> RUN.
    - game_sec is frozen.
    - btn_shot is honoured.
  - SHOT_VIOL:
    - game_sec is frozen.
    - btn_shot -> PAUSE, with reload.
    - btn_start is ignored until the shot clock is reset.
  - QTR_END: btn_start sets quarter+1, game_sec=QTR_SEC and shot_reload, then goes to IDLE.
  - GAME_OVER: absorbing; only Reset_n exits.
- Simultaneous btn_start and btn_shot in RUN or PAUSE: both take effect (state toggles and reload is issued).
- game_sec never wraps: it never decrements below 0.
- Buzzer:
  - On entry to SHOT_VIOL, QTR_END or GAME_OVER: buzzer=1 and buzz count=BUZZ_TICKS.
  - Each tick decrements the count; buzzer=0 when the count reaches 0.
  - Re-entry while buzzing reloads the count (no queuing).
  - Buzzer runs independently of later state changes.
- Latency: all outputs are registered except shot_en. A button pulse is reflected in state one clk later.
- Reset mid-game: all counters return to their reset values immediately (asynchronous). No partial quarter is retained.

Decomposition:
- Shared package bball_pkg holds:
  - the state codes as localparams;
  - SHOT_SEC=24;
  - QTR_SEC and QUARTERS defaults.
  These are shared with the shot-clock counter and the display decoder.
- One natural sub-module, bball_buzz_timer: tick-driven down-counter with load/busy.
- The FSM, game clock and reload stretcher stay in the top level.

Test Plan:
- Reset, then btn_start, then 5 ticks -> state=RUN, game_sec=595, shot_en=1, buzzer=0.
- RUN with shot_zero forced 1 at game_sec=580 -> state=SHOT_VIOL, buzzer=1 for exactly 3 ticks, game_sec holds 580. Then btn_shot -> state=PAUSE, shot_reload high through the next tick.
- QTR_SEC=3 override: start, then 3 ticks with shot_zero=1 on the third -> state=QTR_END (not SHOT_VIOL), game_sec=0. Then btn_start -> quarter=2, game_sec=3, state=IDLE.
- quarter=4 expiry -> GAME_OVER. Then btn_start and btn_shot -> no change. Then Reset_n low mid-cycle -> immediately IDLE, quarter=1, game_sec=600.
- PAUSE with 10 ticks -> game_sec unchanged. btn_start coinciding with a tick in RUN -> state=PAUSE, game_sec decremented exactly once.
